// File: rtl/iris_argmax_classifier.sv
// Argmax stage for the Iris output layer: scans the NUM_CLASSES signed neuron
// outputs one compare per cycle and reports the index and value of the largest.
module iris_argmax_classifier #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 3,
  parameter int CLASS_BITS  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              En,
  input  logic                              Start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] Y_bus,
  output logic [CLASS_BITS-1:0]             Class,
  output logic [DATA_WIDTH-1:0]             Max_Val,
  output logic                              Busy,
  output logic                              Done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [CLASS_BITS-1:0] LAST_IDX = CLASS_BITS'(NUM_CLASSES - 1);
  localparam logic [CLASS_BITS-1:0] ONE_IDX  = CLASS_BITS'(1);

  state_t                        state_r;
  state_t                        next_state_s;
  logic signed [DATA_WIDTH-1:0]  yr_r [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0]  best_val_r;
  logic        [CLASS_BITS-1:0]  best_idx_r;
  logic        [CLASS_BITS-1:0]  idx_r;
  logic signed [DATA_WIDTH-1:0]  cur_s;

  // State register, frozen whenever En is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (En) begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD:    next_state_s = COMPARE;
      COMPARE: begin
        if (idx_r == LAST_IDX) begin
          next_state_s = RESULT;
        end else begin
          next_state_s = COMPARE;
        end
      end
      RESULT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    Busy = (state_r != IDLE);
  end

  // Select the captured value addressed by idx; out-of-range indices fall back to slot 0
  always_comb begin
    cur_s = yr_r[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      cur_s = (idx_r == CLASS_BITS'(k)) ? yr_r[k] : cur_s;
    end
  end

  // Datapath: capture, running max/argmax, result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        yr_r[k] <= '0;
      end
      best_val_r <= '0;
      best_idx_r <= '0;
      idx_r      <= '0;
      Class      <= '0;
      Max_Val    <= '0;
      Done       <= 1'b0;
    end else if (En) begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
        end
        LOAD: begin
          for (int k = 0; k < NUM_CLASSES; k++) begin
            yr_r[k] <= Y_bus[k*DATA_WIDTH +: DATA_WIDTH];
          end
          best_val_r <= Y_bus[DATA_WIDTH-1:0];
          best_idx_r <= '0;
          idx_r      <= ONE_IDX;
          Done       <= 1'b0;
        end
        COMPARE: begin
          // Strict greater-than keeps the lowest index among equal maxima
          if (cur_s > best_val_r) begin
            best_val_r <= cur_s;
            best_idx_r <= idx_r;
          end
          idx_r <= idx_r + ONE_IDX;
          Done  <= 1'b0;
        end
        RESULT: begin
          Class   <= best_idx_r;
          Max_Val <= best_val_r;
          Done    <= 1'b1;
        end
        default: begin
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule
